// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative multiply/divide engine and
// the control unit that drives it.
package muldiv_pkg;

  localparam int MD_ITER  = 32;
  localparam int MD_CNT_W = 6;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MULT = 2'd1,
    DIV  = 2'd2,
    DONE = 2'd3
  } md_state_t;

  typedef enum logic {
    MD_MULT = 1'b0,
    MD_DIV  = 1'b1
  } md_op_t;

endpackage

// File: rtl/muldiv_unit.sv
// Shared signed multiply (radix-2 Booth) / divide (restoring on magnitudes)
// engine producing HI/LO with a fixed 33-cycle latency.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int ITER = MD_ITER
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic        op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic        div_by_zero,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [MD_CNT_W-1:0] CNT_LAST = MD_CNT_W'(ITER - 1);

  md_state_t           state_q, state_d;
  logic [MD_CNT_W-1:0] cnt_q, cnt_d;
  logic [32:0]         work_hi_q, work_hi_d;
  logic [31:0]         work_lo_q, work_lo_d;
  logic                q_m1_q, q_m1_d;
  logic [31:0]         opnd_q, opnd_d;
  logic                neg_q_q, neg_q_d;
  logic                neg_r_q, neg_r_d;
  logic [31:0]         hi_q, hi_d;
  logic [31:0]         lo_q, lo_d;
  logic                dbz_q, dbz_d;

  logic [32:0] acc_sum, booth_hi, div_shift, div_diff;
  logic [31:0] booth_lo, div_hi, div_lo;
  logic        div_fits;

  function automatic logic [31:0] mag32(input logic [31:0] x);
    return x[31] ? (32'd0 - x) : x;
  endfunction

  // Accumulator carries a guard bit so that subtracting -2^31 cannot overflow.
  always_comb begin
    case ({work_lo_q[0], q_m1_q})
      2'b01:   acc_sum = work_hi_q + {opnd_q[31], opnd_q};
      2'b10:   acc_sum = work_hi_q - {opnd_q[31], opnd_q};
      default: acc_sum = work_hi_q;
    endcase
    booth_hi = {acc_sum[32], acc_sum[32:1]};
    booth_lo = {acc_sum[0], work_lo_q[31:1]};
  end

  always_comb begin
    div_shift = {work_hi_q[31:0], work_lo_q[31]};
    div_diff  = div_shift - {1'b0, opnd_q};
    div_fits  = ~div_diff[32];
    div_hi    = div_fits ? div_diff[31:0] : div_shift[31:0];
    div_lo    = {work_lo_q[30:0], div_fits};
  end

  // states: IDLE wait start | MULT booth step | DIV restore step | DONE results valid
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    work_hi_d = work_hi_q;
    work_lo_d = work_lo_q;
    q_m1_d    = q_m1_q;
    opnd_d    = opnd_q;
    neg_q_d   = neg_q_q;
    neg_r_d   = neg_r_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    dbz_d     = dbz_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          dbz_d = 1'b0;
          cnt_d = CNT_LAST;
          if (md_op_t'(op) == MD_DIV) begin
            if (b == 32'd0) begin
              dbz_d   = 1'b1;
              state_d = DONE;
            end else begin
              work_hi_d = '0;
              work_lo_d = mag32(a);
              opnd_d    = mag32(b);
              neg_q_d   = a[31] ^ b[31];
              neg_r_d   = a[31];
              state_d   = DIV;
            end
          end else begin
            work_hi_d = '0;
            work_lo_d = b;
            q_m1_d    = 1'b0;
            opnd_d    = a;
            state_d   = MULT;
          end
        end
      end
      MULT: begin
        work_hi_d = booth_hi;
        work_lo_d = booth_lo;
        q_m1_d    = work_lo_q[0];
        if (cnt_q == '0) begin
          hi_d    = booth_hi[31:0];
          lo_d    = booth_lo;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DIV: begin
        work_hi_d = {1'b0, div_hi};
        work_lo_d = div_lo;
        if (cnt_q == '0) begin
          hi_d    = neg_r_q ? (32'd0 - div_hi) : div_hi;
          lo_d    = neg_q_q ? (32'd0 - div_lo) : div_lo;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      work_hi_q <= '0;
      work_lo_q <= '0;
      q_m1_q    <= 1'b0;
      opnd_q    <= '0;
      neg_q_q   <= 1'b0;
      neg_r_q   <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      work_hi_q <= work_hi_d;
      work_lo_q <= work_lo_d;
      q_m1_q    <= q_m1_d;
      opnd_q    <= opnd_d;
      neg_q_q   <= neg_q_d;
      neg_r_q   <= neg_r_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      dbz_q     <= dbz_d;
    end
  end

  assign busy        = (state_q != IDLE);
  assign done        = (state_q == DONE);
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, randomized ops against an
// arithmetic reference model, and multi-cycle handshake corner cases.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic        clock;
  logic        reset;
  logic        start;
  logic        op;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int checks   = 0;
  int failures = 0;

  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  muldiv_unit dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero),
    .hi          (hi),
    .lo          (lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
    int          lat;
  } vec_t;

  vec_t vecs[12];

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", nm, got, exp);
    end
  endtask

  // Reference: plain 64-bit signed arithmetic; C-style truncating division.
  function automatic void model(input logic o, input logic [31:0] av, input logic [31:0] bv,
                                output logic [31:0] e_hi, output logic [31:0] e_lo,
                                output logic e_dbz, output int e_lat);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = $signed(av);
    sb = $signed(bv);
    e_dbz = 1'b0;
    e_lat = 33;
    if (o == MD_MULT) begin
      p = 64'(sa * sb);
      e_hi = p[63:32];
      e_lo = p[31:0];
    end else if (bv == 32'd0) begin
      e_hi = m_hi;
      e_lo = m_lo;
      e_dbz = 1'b1;
      e_lat = 1;
    end else begin
      q = sa / sb;
      r = sa % sb;
      e_lo = q[31:0];
      e_hi = r[31:0];
    end
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'($urandom_range(0, 40)) - 32'd20;
      1: return 32'h80000000;
      2: return 32'hFFFFFFFF;
      3: return 32'd0;
      default: return $urandom;
    endcase
  endfunction

  task automatic run_op(input logic o, input logic [31:0] av, input logic [31:0] bv,
                        input int glitch_at,
                        output logic [31:0] g_hi, output logic [31:0] g_lo,
                        output logic g_dbz, output int lat, output int busy_cnt,
                        output logic tail_ok);
    @(negedge clock);
    start = 1'b1; op = o; a = av; b = bv;
    @(negedge clock);
    start = 1'b0; a = $urandom; b = $urandom; op = 1'($urandom);
    lat = 1;
    busy_cnt = int'(busy);
    while (!done && lat < 100) begin
      if (lat == glitch_at) begin
        start = 1'b1; a = $urandom; b = $urandom; op = 1'($urandom);
      end else begin
        start = 1'b0;
      end
      @(negedge clock);
      lat++;
      busy_cnt += int'(busy);
    end
    start = 1'b0;
    g_hi = hi;
    g_lo = lo;
    g_dbz = div_by_zero;
    @(negedge clock);
    tail_ok = !done && !busy && (div_by_zero == g_dbz) && (hi == g_hi) && (lo == g_lo);
  endtask

  task automatic do_check(input string nm, input logic o, input logic [31:0] av,
                          input logic [31:0] bv, input int glitch_at,
                          input logic [31:0] e_hi, input logic [31:0] e_lo,
                          input logic e_dbz, input int e_lat);
    logic [31:0] g_hi, g_lo;
    logic g_dbz, tail_ok;
    int lat, busy_cnt;
    run_op(o, av, bv, glitch_at, g_hi, g_lo, g_dbz, lat, busy_cnt, tail_ok);
    chk({nm, ".hi"}, g_hi, e_hi);
    chk({nm, ".lo"}, g_lo, e_lo);
    chk({nm, ".dbz"}, 32'(g_dbz), 32'(e_dbz));
    chk({nm, ".latency"}, lat, e_lat);
    chk({nm, ".busy_cycles"}, busy_cnt, e_lat);
    chk({nm, ".after_done"}, 32'(tail_ok), 32'd1);
    m_hi = e_hi;
    m_lo = e_lo;
  endtask

  task automatic held(input string nm, input logic o, input logic [31:0] av,
                      input logic [31:0] bv, input int exp_gap);
    int n, gap;
    @(negedge clock);
    start = 1'b1; op = o; a = av; b = bv;
    n = 0;
    while (!done && n < 100) begin
      @(negedge clock);
      n++;
    end
    chk({nm, ".first_done"}, 32'(done), 32'd1);
    @(negedge clock);
    gap = 1;
    while (!done && gap < 100) begin
      @(negedge clock);
      gap++;
    end
    start = 1'b0;
    chk({nm, ".gap"}, gap, exp_gap);
    n = 0;
    while ((busy || done) && n < 100) begin
      @(negedge clock);
      n++;
    end
  endtask

  initial begin
    logic [31:0] e_hi, e_lo, ra, rb;
    logic e_dbz, ro;
    int e_lat, dcnt, n;

    vecs[0]  = '{MD_MULT, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33};
    vecs[1]  = '{MD_MULT, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 33};
    vecs[2]  = '{MD_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33};
    vecs[3]  = '{MD_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 1'b0, 33};
    vecs[4]  = '{MD_MULT, 32'd3,        32'h55555556, 32'd1,        32'd2,        1'b0, 33};
    vecs[5]  = '{MD_DIV,  32'd5,        32'd0,        32'd1,        32'd2,        1'b1, 1};
    vecs[6]  = '{MD_MULT, 32'd3,        32'd4,        32'd0,        32'd12,       1'b0, 33};
    vecs[7]  = '{MD_DIV,  32'd100,      32'd7,        32'd2,        32'd14,       1'b0, 33};
    vecs[8]  = '{MD_DIV,  32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0, 33};
    vecs[9]  = '{MD_DIV,  32'hFFFFFFF8, 32'hFFFFFFFD, 32'hFFFFFFFE, 32'd2,        1'b0, 33};
    vecs[10] = '{MD_MULT, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0,        32'd1,        1'b0, 33};
    vecs[11] = '{MD_DIV,  32'd3,        32'd7,        32'd3,        32'd0,        1'b0, 33};

    reset = 1'b1; start = 1'b0; op = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clock);
    chk("reset.busy", 32'(busy), 32'd0);
    chk("reset.done", 32'(done), 32'd0);
    chk("reset.dbz", 32'(div_by_zero), 32'd0);
    chk("reset.hi", hi, 32'd0);
    chk("reset.lo", lo, 32'd0);
    reset = 1'b0;

    for (int i = 0; i < 12; i++) begin
      do_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b, 0,
               vecs[i].hi, vecs[i].lo, vecs[i].dbz, vecs[i].lat);
    end

    for (int i = 0; i < 40; i++) begin
      ro = 1'($urandom);
      ra = pick();
      rb = pick();
      model(ro, ra, rb, e_hi, e_lo, e_dbz, e_lat);
      do_check($sformatf("rand%0d", i), ro, ra, rb, 0, e_hi, e_lo, e_dbz, e_lat);
    end

    model(MD_MULT, 32'h00012345, 32'hFFFFFFB3, e_hi, e_lo, e_dbz, e_lat);
    do_check("glitch_mult", MD_MULT, 32'h00012345, 32'hFFFFFFB3, 10, e_hi, e_lo, e_dbz, e_lat);
    model(MD_DIV, 32'hDEADBEEF, 32'h00001234, e_hi, e_lo, e_dbz, e_lat);
    do_check("glitch_div", MD_DIV, 32'hDEADBEEF, 32'h00001234, 10, e_hi, e_lo, e_dbz, e_lat);

    model(MD_MULT, 32'd1234567, 32'hFFFF0001, e_hi, e_lo, e_dbz, e_lat);
    held("held_mult", MD_MULT, 32'd1234567, 32'hFFFF0001, 34);
    chk("held_mult.hi", hi, e_hi);
    chk("held_mult.lo", lo, e_lo);
    m_hi = e_hi;
    m_lo = e_lo;
    held("held_dbz", MD_DIV, 32'd9, 32'd0, 2);
    chk("held_dbz.flag", 32'(div_by_zero), 32'd1);
    chk("held_dbz.hi", hi, m_hi);
    chk("held_dbz.lo", lo, m_lo);

    do_check("pre_abort", MD_MULT, 32'd3, 32'h55555556, 0, 32'd1, 32'd2, 1'b0, 33);
    @(negedge clock);
    start = 1'b1; op = MD_DIV; a = 32'd1000; b = 32'd7;
    @(negedge clock);
    start = 1'b0;
    n = 1;
    while (n < 12) begin
      @(negedge clock);
      n++;
    end
    reset = 1'b1;
    @(negedge clock);
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.hi", hi, 32'd0);
    chk("abort.lo", lo, 32'd0);
    chk("abort.dbz", 32'(div_by_zero), 32'd0);
    reset = 1'b0;
    dcnt = 0;
    repeat (40) begin
      @(negedge clock);
      if (done) dcnt++;
    end
    chk("abort.no_done", dcnt, 0);
    m_hi = 32'd0;
    m_lo = 32'd0;
    do_check("post_abort", MD_MULT, 32'd3, 32'd4, 0, 32'd0, 32'd12, 1'b0, 33);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
